// File: rtl/pwm_ramp_ctrl_if.sv
// Configuration handshake between the register interface and the PWM ramp sequencer.
interface pwm_ramp_ctrl_if #(
    parameter int CNT_WIDTH = 32,
    parameter int DIV_WIDTH = 16
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CNT_WIDTH-1:0] cfg_period;
    logic [CNT_WIDTH-1:0] cfg_duty;
    logic [CNT_WIDTH-1:0] cfg_step;
    logic [DIV_WIDTH-1:0] cfg_div;

    modport master (
        output cfg_valid, cfg_period, cfg_duty, cfg_step, cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_period, cfg_duty, cfg_step, cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Applies period/duty targets to the PWM core on period boundaries, optionally
// ramping duty by a fixed step every N periods.
//
// state | meaning
// IDLE  | nothing applied since reset, core runs its defaults
// ARM   | config latched, waiting for period_end (or enable low) to apply
// RAMP  | stepping duty toward target on period boundaries
// HOLD  | target reached, outputs static
module pwm_ramp_ctrl #(
    parameter int CNT_WIDTH             = 32,
    parameter int DEFAULT_PERIOD_CYCLES = 5000,
    parameter int DIV_WIDTH             = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 period_end,
    pwm_ramp_ctrl_if.slave       cfg,
    output logic [CNT_WIDTH-1:0] period_cycles_o,
    output logic [CNT_WIDTH-1:0] duty_cycles_o,
    output logic                 use_default_duty_o,
    output logic                 busy,
    output logic                 ramp_done
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] RAMP = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    localparam logic [CNT_WIDTH-1:0] DEF_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD_CYCLES);

    logic [1:0]           state;
    logic                 cfg_ready_r;
    logic [CNT_WIDTH-1:0] sh_period;
    logic [CNT_WIDTH-1:0] sh_duty;
    logic [CNT_WIDTH-1:0] sh_step;
    logic [DIV_WIDTH-1:0] sh_div;
    logic [CNT_WIDTH-1:0] target;
    logic [DIV_WIDTH-1:0] div_cnt;

    logic [CNT_WIDTH-1:0] eff_period;
    logic [CNT_WIDTH-1:0] apply_target;
    logic [DIV_WIDTH-1:0] div_load;
    logic [CNT_WIDTH:0]   up_sum;
    logic [CNT_WIDTH:0]   down_gap;
    logic [CNT_WIDTH-1:0] stepped_duty;

    assign cfg.cfg_ready = cfg_ready_r;
    assign busy          = (state == ARM) || (state == RAMP);

    always_comb begin
        eff_period   = (sh_period == '0) ? DEF_PERIOD : sh_period;
        apply_target = (sh_duty > eff_period) ? eff_period : sh_duty;
        div_load     = (sh_div == '0) ? '0 : sh_div - DIV_WIDTH'(1);
    end

    // One extra bit keeps the step from wrapping; the result saturates at target.
    always_comb begin
        up_sum       = {1'b0, duty_cycles_o} + {1'b0, sh_step};
        down_gap     = {1'b0, duty_cycles_o} - {1'b0, target};
        stepped_duty = target;
        if (target > duty_cycles_o) begin
            if (up_sum < {1'b0, target}) begin
                stepped_duty = up_sum[CNT_WIDTH-1:0];
            end
        end else if (down_gap > {1'b0, sh_step}) begin
            stepped_duty = duty_cycles_o - sh_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            cfg_ready_r        <= 1'b1;
            period_cycles_o    <= '0;
            duty_cycles_o      <= '0;
            use_default_duty_o <= 1'b1;
            ramp_done          <= 1'b0;
            sh_period          <= '0;
            sh_duty            <= '0;
            sh_step            <= '0;
            sh_div             <= '0;
            target             <= '0;
            div_cnt            <= '0;
        end else begin
            ramp_done <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    if (cfg.cfg_valid && cfg_ready_r) begin
                        sh_period   <= cfg.cfg_period;
                        sh_duty     <= cfg.cfg_duty;
                        sh_step     <= cfg.cfg_step;
                        sh_div      <= cfg.cfg_div;
                        state       <= ARM;
                        cfg_ready_r <= 1'b0;
                    end
                end
                ARM: begin
                    if (!enable || period_end) begin
                        period_cycles_o    <= sh_period;
                        use_default_duty_o <= 1'b0;
                        target             <= apply_target;
                        if ((sh_step == '0) || (duty_cycles_o == apply_target)) begin
                            duty_cycles_o <= apply_target;
                            state         <= HOLD;
                            cfg_ready_r   <= 1'b1;
                            ramp_done     <= 1'b1;
                        end else begin
                            state   <= RAMP;
                            div_cnt <= div_load;
                        end
                    end
                end
                RAMP: begin
                    if (!enable) begin
                        duty_cycles_o <= target;
                        state         <= HOLD;
                        cfg_ready_r   <= 1'b1;
                        ramp_done     <= 1'b1;
                    end else if (period_end) begin
                        if (div_cnt == '0) begin
                            duty_cycles_o <= stepped_duty;
                            div_cnt       <= div_load;
                            if (stepped_duty == target) begin
                                state       <= HOLD;
                                cfg_ready_r <= 1'b1;
                                ramp_done   <= 1'b1;
                            end
                        end else begin
                            div_cnt <= div_cnt - DIV_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    cfg_ready_r <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level model.
module tb_pwm_ramp_ctrl;
    localparam int CW = 32;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic period_end = 1'b0;
    logic [CW-1:0] period_cycles_o, duty_cycles_o;
    logic use_default_duty_o, busy, ramp_done;

    pwm_ramp_ctrl_if #(.CNT_WIDTH(CW), .DIV_WIDTH(DW)) cfg_if ();

    pwm_ramp_ctrl #(.CNT_WIDTH(CW), .DEFAULT_PERIOD_CYCLES(5000), .DIV_WIDTH(DW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .enable             (enable),
        .period_end         (period_end),
        .cfg                (cfg_if),
        .period_cycles_o    (period_cycles_o),
        .duty_cycles_o      (duty_cycles_o),
        .use_default_duty_o (use_default_duty_o),
        .busy               (busy),
        .ramp_done          (ramp_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit pe_random = 1'b0;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint m_period = 0, m_duty = 0, m_target = 0;
    bit     m_usedef = 1, m_done = 0, m_pending = 0, m_ramping = 0;
    longint s_period = 0, s_duty = 0, s_step = 0, s_div = 0;
    int     pe_seen = 0, divn = 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_period = 0; m_duty = 0; m_usedef = 1; m_done = 0;
            m_pending = 0; m_ramping = 0; m_target = 0;
        end else begin
            longint plim;
            m_done = 0;
            if (m_pending) begin
                if (!enable || period_end) begin
                    m_pending = 0;
                    m_period  = s_period;
                    m_usedef  = 0;
                    plim      = (s_period == 0) ? 5000 : s_period;
                    m_target  = (s_duty < plim) ? s_duty : plim;
                    if (s_step == 0 || m_duty == m_target) begin
                        m_duty = m_target;
                        m_done = 1;
                    end else begin
                        m_ramping = 1;
                        pe_seen   = 0;
                        divn      = (s_div == 0) ? 1 : int'(s_div);
                    end
                end
            end else if (m_ramping) begin
                if (!enable) begin
                    m_duty = m_target; m_ramping = 0; m_done = 1;
                end else if (period_end) begin
                    pe_seen++;
                    if (pe_seen == divn) begin
                        pe_seen = 0;
                        if (m_target > m_duty)
                            m_duty = (m_duty + s_step < m_target) ? m_duty + s_step : m_target;
                        else
                            m_duty = (m_duty - s_step > m_target) ? m_duty - s_step : m_target;
                        if (m_duty == m_target) begin
                            m_ramping = 0; m_done = 1;
                        end
                    end
                end
            end else if (cfg_if.cfg_valid) begin
                s_period  = cfg_if.cfg_period;
                s_duty    = cfg_if.cfg_duty;
                s_step    = cfg_if.cfg_step;
                s_div     = cfg_if.cfg_div;
                m_pending = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("period", period_cycles_o, m_period);
            chk("duty", duty_cycles_o, m_duty);
            chk("use_default", use_default_duty_o, longint'(m_usedef));
            chk("cfg_ready", cfg_if.cfg_ready, longint'(!(m_pending || m_ramping)));
            chk("busy", busy, longint'(m_pending || m_ramping));
            chk("ramp_done", ramp_done, longint'(m_done));
        end
    end

    // Record each change of duty for sequence checks.
    logic [CW-1:0] dq[$];
    logic [CW-1:0] last_duty = '0;
    always @(negedge clk) begin
        if (duty_cycles_o != last_duty) begin
            dq.push_back(duty_cycles_o);
            last_duty = duty_cycles_o;
        end
    end

    // period_end pulse generator
    initial begin
        int cnt;
        cnt = 4;
        forever begin
            @(posedge clk); #1;
            if (cnt <= 1) begin
                period_end = 1'b1;
                cnt = pe_random ? int'($urandom_range(1, 8)) : 4;
            end else begin
                period_end = 1'b0;
                cnt--;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_cfg(logic [CW-1:0] p, logic [CW-1:0] d, logic [CW-1:0] s, logic [DW-1:0] dv);
        int guard;
        guard = 0;
        while (!cfg_if.cfg_ready && guard < 5000) begin
            step();
            guard++;
        end
        chk("ready_wait", cfg_if.cfg_ready, 1);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_period = p;
        cfg_if.cfg_duty   = d;
        cfg_if.cfg_step   = s;
        cfg_if.cfg_div    = dv;
        step();
        cfg_if.cfg_valid  = 1'b0;
    endtask

    task automatic wait_done(string nm, logic [CW-1:0] exp_duty);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ramp_done && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk({nm, "_done_seen"}, ramp_done, 1);
        chk({nm, "_duty_at_done"}, duty_cycles_o, exp_duty);
        step();
    endtask

    task automatic chk_q(string nm, int n, logic [CW-1:0] e0, logic [CW-1:0] e1, logic [CW-1:0] e2);
        logic [CW-1:0] e[3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        chk({nm, "_len"}, dq.size(), n);
        for (int i = 0; i < n && i < dq.size(); i++) chk(nm, dq[i], e[i]);
    endtask

    task automatic chk_reset_vals(string nm);
        chk({nm, "_period"}, period_cycles_o, 0);
        chk({nm, "_duty"}, duty_cycles_o, 0);
        chk({nm, "_usedef"}, use_default_duty_o, 1);
        chk({nm, "_ready"}, cfg_if.cfg_ready, 1);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, ramp_done, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_period = '0;
        cfg_if.cfg_duty   = '0;
        cfg_if.cfg_step   = '0;
        cfg_if.cfg_div    = '0;
        repeat (2) step();
        rst_n = 1'b1;
        enable = 1'b1;
        repeat (5) step();
        chk_reset_vals("post_reset");

        // immediate apply, waits for period boundary
        send_cfg(32'd1000, 32'd300, 32'd0, 16'd0);
        @(negedge clk);
        chk("arm_ready_low", cfg_if.cfg_ready, 0);
        chk("arm_duty_unchanged", duty_cycles_o, 0);
        chk("arm_period_unchanged", period_cycles_o, 0);
        wait_done("imm", 32'd300);
        chk("imm_period", period_cycles_o, 1000);
        chk("imm_usedef", use_default_duty_o, 0);
        @(negedge clk);
        chk("imm_done_single", ramp_done, 0);
        chk("imm_ready_back", cfg_if.cfg_ready, 1);
        step();

        // ramp up 0 -> 50 step 20 every 2 periods
        send_cfg(32'd100, 32'd0, 32'd0, 16'd0);
        wait_done("zero", 32'd0);
        dq.delete();
        send_cfg(32'd100, 32'd50, 32'd20, 16'd2);
        wait_done("up", 32'd50);
        chk_q("up_seq", 3, 32'd20, 32'd40, 32'd50);

        // ramp down 50 -> 5 step 20 every period
        dq.delete();
        send_cfg(32'd100, 32'd5, 32'd20, 16'd0);
        wait_done("down", 32'd5);
        chk_q("down_seq", 3, 32'd30, 32'd10, 32'd5);

        // default-period clamping
        send_cfg(32'd0, 32'd2000, 32'd0, 16'd0);
        wait_done("clamp_lo", 32'd2000);
        chk("clamp_lo_period", period_cycles_o, 0);
        send_cfg(32'd0, 32'd7000, 32'd0, 16'd0);
        wait_done("clamp_hi", 32'd5000);

        // enable falls mid-ramp
        send_cfg(32'd0, 32'd100, 32'd10, 16'd3);
        repeat (40) step();
        chk("midramp_busy", busy, 1);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("en_drop_duty", duty_cycles_o, 100);
        chk("en_drop_done", ramp_done, 1);
        chk("en_drop_busy", busy, 0);
        step();
        enable = 1'b1;

        // asynchronous reset mid-ramp
        send_cfg(32'd0, 32'd3000, 32'd7, 16'd1);
        repeat (30) step();
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        chk_reset_vals("after_reset");

        // saturation near both ends of the range
        send_cfg(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 16'd0);
        wait_done("top", 32'hFFFF_FFFE);
        dq.delete();
        send_cfg(32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFF0, 16'd0);
        wait_done("sat_down", 32'd5);
        chk_q("sat_down_seq", 2, 32'h0000_000E, 32'd5, 32'd0);
        dq.delete();
        send_cfg(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 16'd0);
        wait_done("sat_up", 32'hFFFF_FFFF);
        chk_q("sat_up_seq", 2, 32'hFFFF_FFF5, 32'hFFFF_FFFF, 32'd0);

        // randomized traffic, checked by the model every cycle
        pe_random = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            cfg_if.cfg_valid  = ($urandom_range(0, 7) == 0);
            cfg_if.cfg_period = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, 300));
            cfg_if.cfg_duty   = CW'($urandom_range(0, 6000));
            case ($urandom_range(0, 7))
                0, 1:    cfg_if.cfg_step = '0;
                2:       cfg_if.cfg_step = 32'hFFFF_0000 | CW'($urandom_range(0, 65535));
                default: cfg_if.cfg_step = CW'($urandom_range(50, 1500));
            endcase
            cfg_if.cfg_div = DW'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            step();
        end
        cfg_if.cfg_valid = 1'b0;
        enable = 1'b1;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Sequencer that drives the runtime configuration inputs of the PWM core (period, duty, default-duty select).
- Accepts new period/duty targets through a valid/ready handshake and applies them only on a PWM period boundary, so no glitched or truncated periods occur.
- Optionally ramps duty toward the target by a fixed step every N periods (soft start / soft stop).
- Sits between the register interface and the PWM core.

Parameters:
- CNT_WIDTH, 32, width of period/duty/step values; must match the PWM core.
- DEFAULT_PERIOD_CYCLES, 5000, period used for clamping when the applied period is 0; must match the PWM core.
- DIV_WIDTH, 16, width of the periods-per-step divider.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  PWM enable, same signal fed to the core
- period_end  in  1  one-cycle pulse from the core at end of each PWM period
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  controller can accept a configuration
- cfg_period  in  CNT_WIDTH  target period in cycles; 0 selects the core default
- cfg_duty  in  CNT_WIDTH  target duty in cycles
- cfg_step  in  CNT_WIDTH  duty change per step; 0 means apply immediately
- cfg_div  in  DIV_WIDTH  PWM periods per ramp step; 0 is treated as 1
- period_cycles_o  out  CNT_WIDTH  to core period_cycles_i
- duty_cycles_o  out  CNT_WIDTH  to core duty_cycles_i
- use_default_duty_o  out  1  to core use_default_duty
- busy  out  1  high in ARM or RAMP
- ramp_done  out  1  one-cycle pulse when duty reaches target

Behaviour:
- Reset values (asynchronous):
  - period_cycles_o=0, duty_cycles_o=0, use_default_duty_o=1.
  - cfg_ready=1, busy=0, ramp_done=0, state=IDLE.
  - Shadow registers and divider counter cleared.
- States: IDLE, ARM, RAMP, HOLD.
- cfg_ready is 1 in IDLE and HOLD, 0 in ARM and RAMP. It is registered, so it drops the cycle after acceptance.
- Accept on cfg_valid && cfg_ready. Accepting latches period, duty, step and div into shadow registers and moves the FSM to ARM.
- ARM: wait for period_end while enable=1. If enable=0, apply on the next clk edge. Apply happens in the cycle after the qualifying event and does the following:
  - period_cycles_o <= shadow period; use_default_duty_o <= 0.
  - Target = min(shadow duty, P), where P = shadow period, or DEFAULT_PERIOD_CYCLES when shadow period is 0.
  - If step=0 or duty_cycles_o already equals the target: duty_cycles_o <= target, state <= HOLD, ramp_done pulses.
  - Otherwise: state <= RAMP and the divider is loaded with max(div,1)-1.
- RAMP:
  - On each period_end, if the divider is 0, duty moves one step toward the target and the divider reloads. Otherwise the divider decrements.
  - Step arithmetic uses CNT_WIDTH+1 bits and saturates at the target, with no overshoot in either direction and no wrap past 0 or 2^CNT_WIDTH-1.
  - When the updated duty equals the target: state <= HOLD, ramp_done pulses for exactly one cycle with the final update.
- enable falling in RAMP: duty_cycles_o <= target next cycle, state <= HOLD, ramp_done pulses.
- HOLD: outputs are static. A new accepted configuration goes to ARM. A ramp starts from the current duty_cycles_o, not from 0.
- period_end in IDLE or HOLD is ignored.
- Output changes occur only on the apply cycle or on ramp steps. Both coincide with the cycle after period_end, so the core counter has just wrapped.
- busy = (state==ARM || state==RAMP).
- Reset asserted mid-ramp returns all outputs to reset values immediately. The core then runs default period and default duty.

Test Plan:
- Reset, then enable=1, no cfg -> period_cycles_o=0, use_default_duty_o=1, cfg_ready=1; core runs 5000/2500.
- cfg period=1000, duty=300, step=0 -> cfg_ready low; outputs unchanged until the next period_end; the following cycle period=1000, duty=300, use_default=0; ramp_done single pulse; cfg_ready=1.
- From duty=0: cfg period=100, duty=50, step=20, div=2 -> duty goes 20, 40, 50 on every 2nd period_end after apply; ramp_done with 50; no overshoot.
- From duty=50: cfg duty=5, step=20, div=0 -> duty goes 30, 10, 5 on consecutive period_ends; no underflow.
- cfg duty=2000, period=0 -> target clamped to 2000 ≤ 5000 and applied. Then cfg duty=7000, period=0 -> clamped to 5000.
- Mid-ramp enable=0 -> next cycle duty=target, HOLD, ramp_done. Separately, rst_n low mid-ramp -> immediate reset values.
